// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] s);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4_lane.sv
// Combinational 4:1 selection of one DW-wide lane out of the packed request data.
module mux4_lane
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [NUM_REQ*DW-1:0] din,
  input  logic [SEL_W-1:0]      sel,
  output logic [DW-1:0]         lane
);

  always_comb begin
    lane = '0;
    case (sel)
      2'd0: lane = din[0*DW +: DW];
      2'd1: lane = din[1*DW +: DW];
      2'd2: lane = din[2*DW +: DW];
      2'd3: lane = din[3*DW +: DW];
      default: lane = '0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over 4 requesters with bounded bursts; the granted lane's
// data is forwarded to a registered output one cycle after each beat.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] din,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [SEL_W-1:0]      sel,
  output logic [DW-1:0]         dout,
  output logic                  dout_vld,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  // Scan last+1, last+2, last+3, last; the descending loop lets the nearest hit win.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [SEL_W-1:0]   last);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last + SEL_W'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  arb_state_t         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [DW-1:0]      dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;

  logic               beat;
  logic               rel_grant;
  logic               arbitrate;
  logic [SEL_W:0]     pick;
  logic [DW-1:0]      lane_data;

  mux4_lane #(.DW(DW)) u_lane_mux (
    .din  (din),
    .sel  (sel_q),
    .lane (lane_data)
  );

  always_comb begin
    beat       = (state_q == GRANT) && req[sel_q];
    rel_grant  = (state_q == GRANT) && (!req[sel_q] || (cnt_q == LAST_BEAT));
    arbitrate  = (state_q == IDLE) || rel_grant;
    pick       = rr_pick(req, sel_q);

    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    cnt_d      = beat ? cnt_q + 1'b1 : cnt_q;
    dout_d     = beat ? lane_data : dout_q;
    dout_vld_d = beat;

    if (arbitrate) begin
      if (pick[SEL_W]) begin
        state_d = GRANT;
        sel_d   = pick[SEL_W-1:0];
        gnt_d   = onehot_sel(pick[SEL_W-1:0]);
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '1;
      cnt_q      <= '0;
      gnt_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter with hand-computed grant and data expectations.
module tb_rr_mux_arbiter;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [4*DW-1:0] din;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          busy;

  int   checkCount = 0;
  int   failCount  = 0;
  int   vldPulses  = 0;
  logic beatPrev   = 1'b0;

  rr_mux_arbiter #(.DW(DW), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .sel      (sel),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] laneOf(input int i);
    return din[i*DW +: DW];
  endfunction

  task automatic checkReset(input string tag);
    checkOutput({tag, "_gnt"},  32'(gnt),      32'h0);
    checkOutput({tag, "_sel"},  32'(sel),      32'h3);
    checkOutput({tag, "_dout"}, 32'(dout),     32'h0);
    checkOutput({tag, "_vld"},  32'(dout_vld), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy),     32'h0);
  endtask

  task automatic applyReset(input logic [3:0] r);
    rst_n = 1'b0;
    applyStimulus(r);
    repeat (2) stepCycle();
    checkReset("rst");
    rst_n = 1'b1;
  endtask

  // Every cycle: grant is at most one-hot, and dout_vld follows exactly one cycle after a beat.
  always @(negedge clk) begin
    checkOutput("onehot0_gnt", 32'($onehot0(gnt)), 32'h1);
    if (dout_vld) vldPulses++;
    if (!rst_n) begin
      checkOutput("vld_in_reset", 32'(dout_vld), 32'h0);
      beatPrev <= 1'b0;
    end else begin
      checkOutput("vld_latency", 32'(dout_vld), 32'(beatPrev));
      beatPrev <= busy && |(gnt & req);
    end
  end

  initial begin
    logic [3:0] expG;
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = {8'h44, 8'hA5, 8'h22, 8'h11};

    // All four requesting: 0,1,2,3 each for 4 beats, back to back.
    applyReset(4'b1111);
    stepCycle();
    checkOutput("rr_first_gnt",  32'(gnt),      32'h1);
    checkOutput("rr_first_sel",  32'(sel),      32'h0);
    checkOutput("rr_first_busy", 32'(busy),     32'h1);
    checkOutput("rr_first_vld",  32'(dout_vld), 32'h0);
    for (int k = 2; k <= 16; k++) begin
      stepCycle();
      expG = 4'b0001 << ((k - 1) / 4);
      checkOutput("rr_gnt",  32'(gnt),  32'(expG));
      checkOutput("rr_dout", 32'(dout), 32'(laneOf((k - 2) / 4)));
    end
    stepCycle();
    checkOutput("rr_wrap_gnt",  32'(gnt),  32'h1);
    checkOutput("rr_wrap_dout", 32'(dout), 32'h44);

    // Lone requester 2: re-granted with no idle gap, data streams every cycle.
    applyReset(4'b0100);
    for (int k = 1; k <= 12; k++) begin
      stepCycle();
      checkOutput("solo_gnt",  32'(gnt),  32'h4);
      checkOutput("solo_sel",  32'(sel),  32'h2);
      checkOutput("solo_busy", 32'(busy), 32'h1);
      if (k >= 2) begin
        checkOutput("solo_dout", 32'(dout),     32'hA5);
        checkOutput("solo_vld",  32'(dout_vld), 32'h1);
      end
    end

    // Requester 1 drops after 2 beats: back to IDLE, sel keeps 1, two data pulses.
    applyReset(4'b0010);
    vldPulses = 0;
    stepCycle();
    checkOutput("drop_gnt", 32'(gnt), 32'h2);
    stepCycle();
    stepCycle();
    applyStimulus(4'b0000);
    stepCycle();
    checkOutput("drop_idle_gnt",  32'(gnt),  32'h0);
    checkOutput("drop_idle_busy", 32'(busy), 32'h0);
    checkOutput("drop_idle_sel",  32'(sel),  32'h1);
    repeat (3) stepCycle();
    checkOutput("drop_hold_sel",  32'(sel),       32'h1);
    checkOutput("drop_hold_dout", 32'(dout),      32'h22);
    checkOutput("drop_pulses",    32'(vldPulses), 32'd2);

    // Requester 3 arrives mid-grant of 0: no preemption, takes over after the burst.
    applyReset(4'b0001);
    stepCycle();
    applyStimulus(4'b1001);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("nopre_gnt", 32'(gnt), 32'h1);
    end
    stepCycle();
    checkOutput("nopre_next_gnt", 32'(gnt), 32'h8);
    checkOutput("nopre_next_sel", 32'(sel), 32'h3);

    // Reset during beat 2 clears everything immediately and drops the pending beat.
    applyReset(4'b0100);
    stepCycle();
    stepCycle();
    checkOutput("midrst_pre_vld", 32'(dout_vld), 32'h1);
    rst_n = 1'b0;
    #1;
    checkReset("midrst_now");
    stepCycle();
    checkReset("midrst_held");
    rst_n = 1'b1;
    stepCycle();
    checkOutput("midrst_regrant_gnt", 32'(gnt), 32'h4);
    checkOutput("midrst_regrant_sel", 32'(sel), 32'h2);

    repeat (2) stepCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, data width per requester lane.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, maximum beats per grant (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 4, per-requester request; bit i belongs to requester i.
REQ-006 The block SHALL have port din, input, 4*DW, lane i at din[i*DW +: DW].
REQ-007 The block SHALL have port gnt, output, 4, one-hot grant, registered.
REQ-008 The block SHALL have port sel, output, 2, binary index of the current or last granted requester, registered.
REQ-009 The block SHALL have port dout, output, DW, selected lane data, registered.
REQ-010 The block SHALL have port dout_vld, output, 1, dout holds a valid beat this cycle.
REQ-011 The block SHALL have port busy, output, 1, high while in state GRANT.

Function
REQ-012 The block SHALL implement two states: IDLE (gnt=0) and GRANT (gnt=onehot(sel)).
REQ-013 A beat SHALL be any cycle with state GRANT and req[sel]=1; beat count cnt increments per beat.
REQ-014 Release SHALL occur in GRANT when req[sel]=0, or when a beat occurs with cnt=MAX_BURST-1.
REQ-015 Arbitration SHALL run in IDLE every cycle and in GRANT on the release cycle: winner = first set bit of req scanning sel+1, sel+2, sel+3, sel (mod 4).
REQ-016 On arbitration with a winner, next cycle SHALL be GRANT with sel=winner, gnt=onehot(winner) and cnt=0 -- zero idle cycles between consecutive grants.
REQ-017 On arbitration without a winner, next cycle SHALL be IDLE with gnt=0 and sel unchanged.
REQ-018 A requester released by MAX_BURST that is the only requester SHALL be re-granted the next cycle; when others request, it SHALL be scanned last.
REQ-019 On each beat, dout SHALL capture din lane sel and dout_vld SHALL be 1 in the following cycle (latency 1); otherwise dout_vld=0 and dout holds.
REQ-020 Requests arriving in GRANT for non-granted requesters SHALL not preempt the current grant.
REQ-021 gnt SHALL never have more than one bit set.

Reset
REQ-022 While rst_n=0, outputs SHALL immediately be: state IDLE, gnt=0, sel=3, cnt=0, dout=0, dout_vld=0, busy=0.
REQ-023 With sel=3 after reset, the first arbitration SHALL give priority order 0,1,2,3.
REQ-024 Reset asserted mid-burst SHALL abort the burst without emitting the pending dout_vld.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE, GRANT), requester count (4) and select width (2).
REQ-026 The 4:1 lane select SHALL be a combinational sub-module mux4_lane (parameter DW; inputs din, sel; output lane data).
REQ-027 The rotating priority search SHALL be a function in the block; cnt width SHALL be clog2(MAX_BURST)+1 bits.

Verification
REQ-028 Bench SHALL drive reset release with req=4'b1111 -> gnt sequence 0001,0010,0100,1000, each held 4 beats, with no gaps.
REQ-029 Bench SHALL hold req=4'b0100 continuously with din lane2=8'hA5 -> gnt=0100 re-granted after every 4 beats, and dout=8'hA5 with dout_vld one cycle after each beat.
REQ-030 Bench SHALL set req=4'b0010, drop it after 2 beats, then set req=0 -> release, state IDLE, gnt=0, sel stays 1, exactly 2 dout_vld pulses.
REQ-031 Bench SHALL raise req[3] during a grant to requester 0 -> no preemption; gnt=1000 follows the release of requester 0.
REQ-032 Bench SHALL assert rst_n=0 on beat 2 of a burst -> gnt, dout_vld, and busy go 0 immediately, and sel=3.
REQ-033 Bench SHALL assert onehot0(gnt) every cycle, and dout_vld only the cycle after a beat.
